s2mm_ring_scheduler: RTL and testbench
======================================

# s2mm_ring_scheduler

Sequences DataMover S2MM write commands so ADC capture data lands in a circular DDR3 buffer of fixed-size slots. It sits between the GPIO/host control registers and the DataMover command stream (S_AXIS_S2MM_CMD) in the axi_aclk domain. It issues one command per slot, tracks completions, and withholds commands when the host has not yet consumed slots or the DataMover has too many writes in flight.

## Interface
- BUF_BASE, 32'h0000_0000, byte address of slot 0
- XFER_BYTES, 65536, bytes per slot/command; < 2^23, multiple of 16
- SLOT_BITS, 4, log2 of slot count (NUM_SLOTS = 2^SLOT_BITS)
- MAX_OUTSTANDING, 4, maximum issued-but-not-completed commands (1..NUM_SLOTS)

Ports:
- axi_aclk  in  1  sole clock
- axi_aresetn  in  1  asynchronous, active-low reset
- enable  in  1  run request (level, already synchronous to axi_aclk)
- host_rd_ptr  in  SLOT_BITS+1  host consumption pointer (slot index + wrap bit)
- cmd_tdata  out  72  DataMover command
- cmd_tvalid  out  1  command valid
- cmd_tready  in  1  DataMover accepts command
- s2mm_wr_xfer_cmplt  in  1  one-cycle pulse per completed command
- s2mm_err  in  1  DataMover error
- s2mm_halt  in  1  DataMover halted
- wr_ptr  out  SLOT_BITS+1  completed-slot pointer (slot index + wrap bit)
- outstanding  out  SLOT_BITS+1  issued minus completed
- buf_full  out  1  issue blocked by host pointer
- state  out  2  0 IDLE, 1 RUN, 2 DRAIN, 3 ERROR
- err_sticky  out  1  set on entry to ERROR

## Operation
- Internal pointers: issue_ptr and cmplt_ptr, both SLOT_BITS+1 bits, modular arithmetic.
- wr_ptr = cmplt_ptr.
- outstanding = issue_ptr − cmplt_ptr.
- buf_full = (issue_ptr − host_rd_ptr) == NUM_SLOTS.
- Issue permitted when state is RUN, !buf_full and outstanding < MAX_OUTSTANDING.
- cmd_tdata fields:
  - [22:0] BTT = XFER_BYTES
  - [23] Type = 1
  - [29:24] DSA = 0
  - [30] EOF = 1
  - [31] DRR = 0
  - [63:32] SADDR = BUF_BASE + issue_ptr[SLOT_BITS-1:0]·XFER_BYTES
  - [67:64] TAG = issue_ptr[3:0]
  - [71:68] = 0
- Handshake (cmd_tvalid & cmd_tready) increments issue_ptr.
- Each s2mm_wr_xfer_cmplt increments cmplt_ptr only if outstanding ≠ 0. Otherwise the pulse is ignored.
- State transitions:
  - IDLE → RUN on enable = 1. On that edge, issue_ptr and cmplt_ptr load host_rd_ptr and err_sticky clears.
  - RUN → DRAIN on enable = 0.
  - DRAIN → IDLE when outstanding == 0 and cmd_tvalid == 0.
  - RUN/DRAIN → ERROR on s2mm_err | s2mm_halt; this has priority over every other transition.
  - ERROR → IDLE on enable = 0.
- AXIS rule: once cmd_tvalid rises, it and cmd_tdata hold until the handshake, including across the RUN→DRAIN transition. ERROR is the sole exception: it drops cmd_tvalid immediately, since the DataMover is halted.
- In ERROR, completions are still counted. Pointers freeze otherwise.
- Reset mid-operation: everything returns to reset values at once; no drain.

## Timing
- Reset values:
  - cmd_tvalid 0, cmd_tdata 0
  - issue_ptr, cmplt_ptr, wr_ptr, outstanding 0
  - buf_full follows host_rd_ptr (1 only if host_rd_ptr = NUM_SLOTS)
  - state IDLE, err_sticky 0
- cmd_tvalid and cmd_tdata are registered.
  - cmd_tvalid first asserts the cycle after entering RUN.
  - It stays high on the cycle after a handshake if issue is still permitted using post-increment pointers, giving a sustained throughput of 1 command/cycle.
- Simultaneous handshake and completion in one cycle: both pointers advance; outstanding is unchanged.
- host_rd_ptr changes take effect on buf_full combinationally and on issue the next cycle.
- wr_ptr updates the cycle after the completion pulse.
- state and err_sticky update one cycle after the triggering input.

## Test plan
- **Basic issue.** Parameters BUF_BASE = 0x1000_0000, XFER_BYTES = 0x10000, host_rd_ptr = 0, cmd_tready = 1, no completions; raise enable.
  - Exactly 4 commands issue, with SADDR 0x1000_0000, 0x1001_0000, 0x1002_0000, 0x1003_0000 and TAG 0..3.
  - cmd_tvalid then stays 0 and outstanding = 4.
- **Completion flow.** Same setup; pulse s2mm_wr_xfer_cmplt once per 3 cycles, host_rd_ptr follows wr_ptr.
  - Commands continue without stalling.
  - SADDR wraps from 0x100F_0000 back to 0x1000_0000.
  - wr_ptr bit 4 toggles after slot 15.
- **Full buffer.** host_rd_ptr held at 0, completions immediate.
  - After 16 issues, buf_full = 1 and cmd_tvalid = 0.
  - Setting host_rd_ptr = 1 yields exactly one further command, SADDR 0x1000_0000.
- **Backpressure and drain.** Hold cmd_tready = 0 with cmd_tvalid high, then drop enable.
  - cmd_tdata stays stable and state = DRAIN.
  - Raise cmd_tready for one cycle and complete all 4 commands: state → IDLE and outstanding = 0.
- **Error.** Assert s2mm_err while in RUN with cmd_tvalid = 1.
  - Next cycle: state = 3, err_sticky = 1, cmd_tvalid = 0.
  - Completions still decrement outstanding.
  - enable = 0 returns state to IDLE; re-enable clears err_sticky.
- **Edge cases.**
  - A completion pulse with outstanding = 0 leaves wr_ptr unchanged.
  - A same-cycle handshake and completion keeps outstanding constant.
  - Asserting axi_aresetn low mid-burst zeroes all outputs asynchronously.

Source files
------------

// File: rtl/s2mm_ring_scheduler.sv
// Issues DataMover S2MM write commands, one per fixed-size slot of a circular DDR buffer,
// throttled by the host consumption pointer and a cap on in-flight writes.
module s2mm_ring_scheduler #(
  parameter logic [31:0] BUF_BASE        = 32'h0000_0000,
  parameter int unsigned XFER_BYTES      = 65536,
  parameter int unsigned SLOT_BITS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 enable,
  input  logic [SLOT_BITS:0]   host_rd_ptr,
  output logic [71:0]          cmd_tdata,
  output logic                 cmd_tvalid,
  input  logic                 cmd_tready,
  input  logic                 s2mm_wr_xfer_cmplt,
  input  logic                 s2mm_err,
  input  logic                 s2mm_halt,
  output logic [SLOT_BITS:0]   wr_ptr,
  output logic [SLOT_BITS:0]   outstanding,
  output logic                 buf_full,
  output logic [1:0]           state,
  output logic                 err_sticky
);

  localparam int unsigned   PW          = SLOT_BITS + 1;
  localparam int unsigned   NUM_SLOTS   = 1 << SLOT_BITS;
  localparam logic [PW-1:0] NUM_SLOTS_P = PW'(NUM_SLOTS);
  localparam logic [PW-1:0] MAX_OUT_P   = PW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] ONE         = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] issue_ptr, cmplt_ptr;
  logic [PW-1:0] issue_d, cmplt_d, out_d;
  logic [71:0]   cmd_tdata_d;
  logic          cmd_tvalid_d, err_sticky_d;
  logic          handshake, cmplt_ok, fault, issue_ok_d;

  function automatic logic [71:0] build_cmd(input logic [PW-1:0] ptr);
    logic [31:0] saddr;
    saddr = BUF_BASE + 32'(ptr[SLOT_BITS-1:0]) * 32'(XFER_BYTES);
    return {4'd0, 4'(ptr), saddr, 1'b0, 1'b1, 6'd0, 1'b1, 23'(XFER_BYTES)};
  endfunction

  assign handshake   = cmd_tvalid & cmd_tready;
  assign outstanding = issue_ptr - cmplt_ptr;
  assign cmplt_ok    = s2mm_wr_xfer_cmplt && (outstanding != '0);
  assign fault       = s2mm_err | s2mm_halt;
  assign wr_ptr      = cmplt_ptr;
  assign buf_full    = (issue_ptr - host_rd_ptr) == NUM_SLOTS_P;
  assign state       = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN: begin
        if (fault)        state_d = ST_ERROR;
        else if (!enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fault)                                   state_d = ST_ERROR;
        else if (outstanding == '0 && !cmd_tvalid)  state_d = ST_IDLE;
      end
      ST_ERROR: if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next command is judged on post-update pointers so back-to-back issue sustains 1/cycle.
  always_comb begin
    issue_d      = issue_ptr;
    cmplt_d      = cmplt_ptr;
    err_sticky_d = err_sticky;
    cmd_tvalid_d = cmd_tvalid;
    cmd_tdata_d  = cmd_tdata;

    if (state_q == ST_IDLE && state_d == ST_RUN) begin
      issue_d      = host_rd_ptr;
      cmplt_d      = host_rd_ptr;
      err_sticky_d = 1'b0;
    end else begin
      if (handshake) issue_d = issue_ptr + ONE;
      if (cmplt_ok)  cmplt_d = cmplt_ptr + ONE;
    end
    if (state_d == ST_ERROR && state_q != ST_ERROR) err_sticky_d = 1'b1;

    out_d      = issue_d - cmplt_d;
    issue_ok_d = (state_q == ST_RUN) && (state_d == ST_RUN) &&
                 ((issue_d - host_rd_ptr) != NUM_SLOTS_P) && (out_d < MAX_OUT_P);

    // A presented command is held until accepted; only a halted DataMover withdraws it.
    if (state_d == ST_ERROR) begin
      cmd_tvalid_d = 1'b0;
    end else if (!(cmd_tvalid && !cmd_tready)) begin
      cmd_tvalid_d = issue_ok_d;
      if (issue_ok_d) cmd_tdata_d = build_cmd(issue_d);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= ST_IDLE;
      issue_ptr  <= '0;
      cmplt_ptr  <= '0;
      cmd_tvalid <= 1'b0;
      cmd_tdata  <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_ptr  <= issue_d;
      cmplt_ptr  <= cmplt_d;
      cmd_tvalid <= cmd_tvalid_d;
      cmd_tdata  <= cmd_tdata_d;
      err_sticky <= err_sticky_d;
    end
  end

endmodule

// File: tb/tb_s2mm_ring_scheduler.sv
// Directed scoreboard bench for s2mm_ring_scheduler: expected commands are queued by the
// stimulus and popped by a monitor at every command handshake.
module tb_s2mm_ring_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [4:0]  host_rd_ptr;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic        cmplt;
  logic        s2mm_err;
  logic        s2mm_halt;
  logic [4:0]  wr_ptr;
  logic [4:0]  outstanding;
  logic        buf_full;
  logic [1:0]  state;
  logic        err_sticky;

  int errors = 0;
  int checks = 0;
  int ncmplt = 0;
  logic [71:0] exp_q[$];
  logic [71:0] held;

  s2mm_ring_scheduler #(
    .BUF_BASE(32'h1000_0000),
    .XFER_BYTES(65536),
    .SLOT_BITS(4),
    .MAX_OUTSTANDING(4)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .enable(enable),
    .host_rd_ptr(host_rd_ptr),
    .cmd_tdata(cmd_tdata),
    .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready),
    .s2mm_wr_xfer_cmplt(cmplt),
    .s2mm_err(s2mm_err),
    .s2mm_halt(s2mm_halt),
    .wr_ptr(wr_ptr),
    .outstanding(outstanding),
    .buf_full(buf_full),
    .state(state),
    .err_sticky(err_sticky)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected command for a slot count: low word is BTT=0x10000, Type=1, EOF=1
  function automatic logic [71:0] exp_cmd(input int slot);
    int s;
    s = slot % 16;
    return {4'h0, 4'(s), 32'h1000_0000 + (32'(s) << 16), 32'h4081_0000};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [4:0] host, input logic rdy,
                               input logic cp);
    enable      = en;
    host_rd_ptr = host;
    cmd_tready  = rdy;
    cmplt       = cp;
  endtask

  task automatic checkOutput(input string name, input logic [71:0] actual,
                             input logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every handshake must match the oldest queued command
  always @(negedge clk) begin
    if (rst_n && cmd_tvalid && cmd_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_cmd: got %0h, expected no command", cmd_tdata);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        if (cmd_tdata !== e) begin
          errors++;
          $display("[TB] FAIL cmd_tdata: got %0h, expected %0h", cmd_tdata, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; s2mm_err = 1'b0; s2mm_halt = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_state", 72'(state), 72'(0));
    checkOutput("rst_tvalid", 72'(cmd_tvalid), 72'(0));
    checkOutput("rst_tdata", cmd_tdata, 72'(0));
    checkOutput("rst_wr_ptr", 72'(wr_ptr), 72'(0));
    checkOutput("rst_outstanding", 72'(outstanding), 72'(0));
    checkOutput("rst_err_sticky", 72'(err_sticky), 72'(0));
    checkOutput("rst_buf_full_0", 72'(buf_full), 72'(0));
    host_rd_ptr = 5'd16; #1;
    checkOutput("rst_buf_full_16", 72'(buf_full), 72'(1));
    host_rd_ptr = 5'd0; #1;
    rst_n = 1'b1;
    tick(1);

    $display("[TB] basic issue");
    exp_q.push_back(72'h00_1000_0000_4081_0000);
    exp_q.push_back(72'h01_1001_0000_4081_0000);
    exp_q.push_back(72'h02_1002_0000_4081_0000);
    exp_q.push_back(72'h03_1003_0000_4081_0000);
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0);
    tick(1);
    checkOutput("run_entry_state", 72'(state), 72'(1));
    checkOutput("run_entry_tvalid", 72'(cmd_tvalid), 72'(0));
    tick(1);
    checkOutput("first_tvalid", 72'(cmd_tvalid), 72'(1));
    tick(8);
    checkOutput("basic_tvalid_off", 72'(cmd_tvalid), 72'(0));
    checkOutput("basic_outstanding", 72'(outstanding), 72'(4));
    checkOutput("basic_pending", 72'(exp_q.size()), 72'(0));

    $display("[TB] completion flow");
    for (int s = 4; s < 22; s++) exp_q.push_back(exp_cmd(s));
    for (int i = 0; i < 54; i++) begin
      cmplt = (i % 3 == 0) && (i / 3 < 18);
      tick(1);
      if (cmplt) ncmplt++;
      host_rd_ptr = 5'(ncmplt);
    end
    cmplt = 1'b0;
    tick(6);
    checkOutput("flow_outstanding", 72'(outstanding), 72'(4));
    checkOutput("flow_wr_ptr", 72'(wr_ptr), 72'(18));
    checkOutput("flow_pending", 72'(exp_q.size()), 72'(0));
    enable = 1'b0;
    tick(1);
    checkOutput("flow_drain_state", 72'(state), 72'(2));
    cmplt = 1'b1;
    tick(4);
    cmplt = 1'b0;
    tick(2);
    checkOutput("flow_idle_state", 72'(state), 72'(0));
    checkOutput("flow_idle_wr_ptr", 72'(wr_ptr), 72'(22));

    $display("[TB] full buffer");
    for (int s = 0; s < 16; s++) exp_q.push_back(exp_cmd(s));
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b1);
    tick(25);
    checkOutput("full_buf_full", 72'(buf_full), 72'(1));
    checkOutput("full_tvalid", 72'(cmd_tvalid), 72'(0));
    checkOutput("full_wr_ptr", 72'(wr_ptr), 72'(16));
    checkOutput("full_pending", 72'(exp_q.size()), 72'(0));
    exp_q.push_back(72'h00_1000_0000_4081_0000);
    applyStimulus(1'b1, 5'd1, 1'b1, 1'b0);
    tick(5);
    checkOutput("full_one_more", 72'(exp_q.size()), 72'(0));
    checkOutput("full_again", 72'(buf_full), 72'(1));
    checkOutput("full_outstanding", 72'(outstanding), 72'(1));
    cmplt = 1'b1; tick(1); cmplt = 1'b0; tick(1);
    checkOutput("cmplt_wr_ptr", 72'(wr_ptr), 72'(17));
    cmplt = 1'b1; tick(1); cmplt = 1'b0; tick(1);
    checkOutput("idle_cmplt_wr_ptr", 72'(wr_ptr), 72'(17));
    checkOutput("idle_cmplt_outstanding", 72'(outstanding), 72'(0));

    $display("[TB] backpressure and drain");
    for (int s = 17; s < 21; s++) exp_q.push_back(exp_cmd(s));
    applyStimulus(1'b1, 5'd17, 1'b1, 1'b0);
    tick(8);
    checkOutput("bp_outstanding", 72'(outstanding), 72'(4));
    exp_q.push_back(72'h05_1005_0000_4081_0000);
    applyStimulus(1'b1, 5'd17, 1'b0, 1'b1);
    tick(1);
    cmplt = 1'b0;
    tick(2);
    checkOutput("bp_tvalid", 72'(cmd_tvalid), 72'(1));
    held = cmd_tdata;
    checkOutput("bp_tdata", held, 72'h05_1005_0000_4081_0000);
    enable = 1'b0;
    tick(1);
    checkOutput("bp_drain_state", 72'(state), 72'(2));
    tick(3);
    checkOutput("bp_drain_tvalid", 72'(cmd_tvalid), 72'(1));
    checkOutput("bp_drain_tdata", cmd_tdata, held);
    cmd_tready = 1'b1;
    tick(1);
    cmd_tready = 1'b0;
    checkOutput("bp_after_hs_tvalid", 72'(cmd_tvalid), 72'(0));
    checkOutput("bp_after_hs_outstanding", 72'(outstanding), 72'(4));
    cmplt = 1'b1;
    tick(4);
    cmplt = 1'b0;
    tick(2);
    checkOutput("bp_idle_state", 72'(state), 72'(0));
    checkOutput("bp_idle_outstanding", 72'(outstanding), 72'(0));
    checkOutput("bp_pending", 72'(exp_q.size()), 72'(0));

    $display("[TB] error");
    for (int s = 22; s < 26; s++) exp_q.push_back(exp_cmd(s));
    applyStimulus(1'b1, 5'd22, 1'b1, 1'b0);
    tick(8);
    checkOutput("err_pre_outstanding", 72'(outstanding), 72'(4));
    applyStimulus(1'b1, 5'd22, 1'b0, 1'b1);
    tick(1);
    cmplt = 1'b0;
    tick(2);
    checkOutput("err_pre_tvalid", 72'(cmd_tvalid), 72'(1));
    checkOutput("err_pre_tdata", cmd_tdata, 72'h0A_100A_0000_4081_0000);
    s2mm_err = 1'b1;
    tick(1);
    s2mm_err = 1'b0;
    checkOutput("err_state", 72'(state), 72'(3));
    checkOutput("err_sticky_set", 72'(err_sticky), 72'(1));
    checkOutput("err_tvalid", 72'(cmd_tvalid), 72'(0));
    checkOutput("err_outstanding", 72'(outstanding), 72'(3));
    cmplt = 1'b1; tick(1); cmplt = 1'b0; tick(1);
    checkOutput("err_cmplt_outstanding", 72'(outstanding), 72'(2));
    checkOutput("err_cmplt_wr_ptr", 72'(wr_ptr), 72'(24));
    enable = 1'b0;
    tick(1);
    checkOutput("err_exit_state", 72'(state), 72'(0));
    checkOutput("err_exit_sticky", 72'(err_sticky), 72'(1));
    applyStimulus(1'b1, 5'd24, 1'b0, 1'b0);
    tick(1);
    checkOutput("reen_state", 72'(state), 72'(1));
    checkOutput("reen_sticky", 72'(err_sticky), 72'(0));
    tick(2);
    checkOutput("reen_tvalid", 72'(cmd_tvalid), 72'(1));

    $display("[TB] async reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_tvalid", 72'(cmd_tvalid), 72'(0));
    checkOutput("areset_tdata", cmd_tdata, 72'(0));
    checkOutput("areset_state", 72'(state), 72'(0));
    checkOutput("areset_wr_ptr", 72'(wr_ptr), 72'(0));
    checkOutput("areset_outstanding", 72'(outstanding), 72'(0));
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checkOutput("final_pending", 72'(exp_q.size()), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
